hba_master_arbiter: RTL and testbench

Parametrised N-master front end for the HBA bus that replaces unconditional OR-combining of master outputs with registered round-robin arbitration. Each master raises a request, and the arbiter grants exactly one master at a time. Only the granted master's rnw/select/abus/dbus are forwarded to the shared bus, so idle or misbehaving masters cannot corrupt a transfer. A hold-time limit revokes the grant from a master that monopolises the bus while others wait. The block sits between the master peripherals and the HBA slave bus.

---
 rtl/hba_master_arbiter.sv | 142 ++++++++++++++
 tb/tb_hba_master_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hba_master_arbiter.sv
// N-master round-robin front end for the HBA bus: registered one-hot grant,
// hold-time preemption, and grant-gated AND-OR forwarding of master signals.
module hba_master_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int DBUS_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12,
    parameter int MAX_HOLD    = 64
) (
    input  logic                              hba_clk,
    input  logic                              hba_reset,
    input  logic [NUM_MASTERS-1:0]            hba_mreq,
    output logic [NUM_MASTERS-1:0]            hba_mgrant,
    output logic [$clog2(NUM_MASTERS)-1:0]    hba_grant_id,
    output logic                              hba_arb_timeout,
    input  logic [NUM_MASTERS-1:0]            hba_rnw_master,
    input  logic [NUM_MASTERS-1:0]            hba_select_master,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] hba_dbus_master,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] hba_abus_master,
    input  logic [DBUS_WIDTH-1:0]             hba_dbus_slave,
    output logic                              hba_rnw,
    output logic                              hba_select,
    output logic [DBUS_WIDTH-1:0]             hba_dbus,
    output logic [ADDR_WIDTH-1:0]             hba_abus
);

    localparam int ID_W  = $clog2(NUM_MASTERS);
    // A zero MAX_HOLD still gets a 1-bit counter that simply never advances.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
    localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(NUM_MASTERS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [ID_W-1:0]          id_q, id_d;
    logic [ID_W-1:0]          ptr_q, ptr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     timeout_q, timeout_d;

    logic                     winner_found;
    logic [ID_W-1:0]          winner_id;
    logic [ID_W-1:0]          cand;
    logic                     owner_req;
    logic                     others_req;
    logic                     hold_expired;

    // Search starts one past the last owner and wraps, so the last owner is lowest priority.
    always_comb begin
        winner_found = 1'b0;
        winner_id    = '0;
        cand         = '0;
        for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
            cand = ID_W'((32'(ptr_q) + off) % NUM_MASTERS);
            if (!winner_found && hba_mreq[cand]) begin
                winner_found = 1'b1;
                winner_id    = cand;
            end
        end
    end

    assign owner_req    = hba_mreq[id_q];
    assign others_req   = |(hba_mreq & ~grant_q);
    assign hold_expired = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    grant_d = NUM_MASTERS'(1) << winner_id;
                    id_d    = winner_id;
                    ptr_d   = winner_id;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // A voluntary release takes precedence over preemption, suppressing the pulse.
                if (!owner_req) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (hold_expired && others_req && !hba_select) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else if (cnt_q != HOLD_LIM) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge hba_clk or negedge hba_reset) begin
        if (!hba_reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign hba_mgrant      = grant_q;
    assign hba_grant_id    = id_q;
    assign hba_arb_timeout = timeout_q;

    // Each master is gated by its own grant bit, so non-owners contribute zeros.
    always_comb begin
        hba_rnw    = 1'b0;
        hba_select = 1'b0;
        hba_abus   = '0;
        hba_dbus   = hba_dbus_slave;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            hba_rnw    = hba_rnw    | (hba_rnw_master[i]    & grant_q[i]);
            hba_select = hba_select | (hba_select_master[i] & grant_q[i]);
            hba_abus   = hba_abus   | (hba_abus_master[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{grant_q[i]}});
            hba_dbus   = hba_dbus   | (hba_dbus_master[i*DBUS_WIDTH +: DBUS_WIDTH] & {DBUS_WIDTH{grant_q[i]}});
        end
    end

endmodule

// File: tb/tb_hba_master_arbiter.sv
// Directed bench for hba_master_arbiter: one instance with MAX_HOLD=4 and one
// with MAX_HOLD=0 share all inputs; each scenario checks the relevant instance.
module tb_hba_master_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  mreq;
    logic [3:0]  rnw_m;
    logic [3:0]  sel_m;
    logic [31:0] dbus_m;
    logic [47:0] abus_m;
    logic [7:0]  dbus_s;

    logic [3:0]  grant;
    logic [1:0]  gid;
    logic        tmo;
    logic        rnw;
    logic        sel;
    logic [7:0]  dbus;
    logic [11:0] abus;

    logic [3:0]  grant0;
    logic [1:0]  gid0;
    logic        tmo0;
    logic        rnw0;
    logic        sel0;
    logic [7:0]  dbus0;
    logic [11:0] abus0;

    int n_checks = 0;
    int n_fail   = 0;

    hba_master_arbiter #(
        .NUM_MASTERS(4),
        .DBUS_WIDTH (8),
        .ADDR_WIDTH (12),
        .MAX_HOLD   (4)
    ) dut (
        .hba_clk          (clk),
        .hba_reset        (rst_n),
        .hba_mreq         (mreq),
        .hba_mgrant       (grant),
        .hba_grant_id     (gid),
        .hba_arb_timeout  (tmo),
        .hba_rnw_master   (rnw_m),
        .hba_select_master(sel_m),
        .hba_dbus_master  (dbus_m),
        .hba_abus_master  (abus_m),
        .hba_dbus_slave   (dbus_s),
        .hba_rnw          (rnw),
        .hba_select       (sel),
        .hba_dbus         (dbus),
        .hba_abus         (abus)
    );

    hba_master_arbiter #(
        .NUM_MASTERS(4),
        .DBUS_WIDTH (8),
        .ADDR_WIDTH (12),
        .MAX_HOLD   (0)
    ) dut0 (
        .hba_clk          (clk),
        .hba_reset        (rst_n),
        .hba_mreq         (mreq),
        .hba_mgrant       (grant0),
        .hba_grant_id     (gid0),
        .hba_arb_timeout  (tmo0),
        .hba_rnw_master   (rnw_m),
        .hba_select_master(sel_m),
        .hba_dbus_master  (dbus_m),
        .hba_abus_master  (abus_m),
        .hba_dbus_slave   (dbus_s),
        .hba_rnw          (rnw0),
        .hba_select       (sel0),
        .hba_dbus         (dbus0),
        .hba_abus         (abus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        mreq   = '0;
        rnw_m  = '0;
        sel_m  = '0;
        dbus_m = '0;
        abus_m = '0;
        dbus_s = '0;
        rst_n  = 1'b0;
        tick;
        tick;
        rst_n  = 1'b1;
    endtask

    task automatic test_reset;
        dbus_s = 8'h5A;
        mreq   = 4'b1111;
        #2 rst_n = 1'b0;
        #1;
        if (grant !== 4'b0000) begin $display("FAIL reset_grant: got %b want 0000", grant); n_fail++; end
        n_checks++;
        if (gid !== 2'd0) begin $display("FAIL reset_id: got %0d want 0", gid); n_fail++; end
        n_checks++;
        if (tmo !== 1'b0) begin $display("FAIL reset_timeout: got %b want 0", tmo); n_fail++; end
        n_checks++;
        if (sel !== 1'b0 || rnw !== 1'b0 || abus !== 12'h000) begin
            $display("FAIL reset_bus: sel=%b rnw=%b abus=%h want 0/0/000", sel, rnw, abus); n_fail++;
        end
        n_checks++;
        if (dbus !== 8'h5A) begin $display("FAIL reset_dbus: got %h want 5a", dbus); n_fail++; end
        n_checks++;
        tick;
        if (grant !== 4'b0000) begin $display("FAIL reset_held_grant: got %b want 0000", grant); n_fail++; end
        n_checks++;
    endtask

    task automatic test_reset_mid_grant;
        apply_reset;
        mreq = 4'b0100;
        sel_m = 4'b0100;
        dbus_m[2*8 +: 8] = 8'h0F;
        dbus_s = 8'h30;
        tick;
        if (grant !== 4'b0100 || gid !== 2'd2) begin
            $display("FAIL midrst_pre_grant: got %b id %0d want 0100 id 2", grant, gid); n_fail++;
        end
        n_checks++;
        if (sel !== 1'b1 || dbus !== 8'h3F) begin
            $display("FAIL midrst_pre_bus: sel=%b dbus=%h want 1/3f", sel, dbus); n_fail++;
        end
        n_checks++;
        #2 rst_n = 1'b0;
        #1;
        if (grant !== 4'b0000 || gid !== 2'd0) begin
            $display("FAIL midrst_grant: got %b id %0d want 0000 id 0", grant, gid); n_fail++;
        end
        n_checks++;
        if (sel !== 1'b0 || dbus !== 8'h30) begin
            $display("FAIL midrst_bus: sel=%b dbus=%h want 0/30", sel, dbus); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_round_robin;
        int unsigned m;
        apply_reset;
        mreq = 4'b1111;
        for (int unsigned k = 0; k < 5; k++) begin
            m = k % 4;
            tick;
            if (grant !== (4'b0001 << m) || gid !== 2'(m)) begin
                $display("FAIL rr_grant%0d: got %b id %0d want master %0d", k, grant, gid, m); n_fail++;
            end
            n_checks++;
            tick;
            tick;
            if (grant !== (4'b0001 << m)) begin
                $display("FAIL rr_hold%0d: got %b want master %0d", k, grant, m); n_fail++;
            end
            n_checks++;
            mreq[m] = 1'b0;
            tick;
            if (grant !== 4'b0000 || gid !== 2'(m) || tmo !== 1'b0) begin
                $display("FAIL rr_gap%0d: got %b id %0d tmo %b want 0000 id %0d tmo 0", k, grant, gid, tmo, m);
                n_fail++;
            end
            n_checks++;
            mreq[m] = 1'b1;
        end
    endtask

    task automatic test_masking;
        apply_reset;
        mreq = 4'b0010;
        tick;
        abus_m[1*12 +: 12] = 12'h123;
        dbus_m[1*8 +: 8]   = 8'h45;
        abus_m[3*12 +: 12] = 12'hFFF;
        dbus_m[3*8 +: 8]   = 8'hFF;
        rnw_m  = 4'b1000;
        sel_m  = 4'b1010;
        dbus_s = 8'h00;
        #1;
        if (grant !== 4'b0010) begin $display("FAIL mask_grant: got %b want 0010", grant); n_fail++; end
        n_checks++;
        if (abus !== 12'h123 || dbus !== 8'h45 || rnw !== 1'b0 || sel !== 1'b1) begin
            $display("FAIL mask_bus: abus=%h dbus=%h rnw=%b sel=%b want 123/45/0/1", abus, dbus, rnw, sel);
            n_fail++;
        end
        n_checks++;
        dbus_s = 8'h80;
        abus_m[1*12 +: 12] = 12'h456;
        rnw_m[1] = 1'b1;
        #1;
        if (abus !== 12'h456 || dbus !== 8'hC5 || rnw !== 1'b1) begin
            $display("FAIL mask_live: abus=%h dbus=%h rnw=%b want 456/c5/1", abus, dbus, rnw); n_fail++;
        end
        n_checks++;
        mreq = 4'b0000;
        tick;
        if (grant !== 4'b0000 || abus !== 12'h000 || sel !== 1'b0 || rnw !== 1'b0 || dbus !== 8'h80) begin
            $display("FAIL mask_idle: grant=%b abus=%h sel=%b rnw=%b dbus=%h want 0000/000/0/0/80",
                     grant, abus, sel, rnw, dbus);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_no_record;
        apply_reset;
        mreq = 4'b0001;
        tick;
        mreq = 4'b1001;
        tick;
        mreq = 4'b0001;
        tick;
        mreq = 4'b0000;
        tick;
        tick;
        if (grant !== 4'b0000 || gid !== 2'd0) begin
            $display("FAIL norecord: got %b id %0d want 0000 id 0", grant, gid); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_timeout;
        apply_reset;
        sel_m = 4'b0010;
        mreq  = 4'b0001;
        tick;
        mreq = 4'b0011;
        for (int unsigned e = 1; e <= 4; e++) begin
            tick;
            if (grant !== 4'b0001 || tmo !== 1'b0) begin
                $display("FAIL tmo_hold_e%0d: grant=%b tmo=%b want 0001/0", e, grant, tmo); n_fail++;
            end
            n_checks++;
        end
        tick;
        if (grant !== 4'b0000 || tmo !== 1'b1 || gid !== 2'd0) begin
            $display("FAIL tmo_revoke: grant=%b tmo=%b id=%0d want 0000/1/0", grant, tmo, gid); n_fail++;
        end
        n_checks++;
        sel_m = 4'b0000;
        tick;
        if (grant !== 4'b0010 || tmo !== 1'b0 || gid !== 2'd1) begin
            $display("FAIL tmo_next: grant=%b tmo=%b id=%0d want 0010/0/1", grant, tmo, gid); n_fail++;
        end
        n_checks++;
        for (int unsigned e = 1; e <= 4; e++) tick;
        if (grant !== 4'b0010) begin $display("FAIL tmo_m1_hold: got %b want 0010", grant); n_fail++; end
        n_checks++;
        tick;
        if (grant !== 4'b0000 || tmo !== 1'b1) begin
            $display("FAIL tmo_m1_revoke: grant=%b tmo=%b want 0000/1", grant, tmo); n_fail++;
        end
        n_checks++;
        tick;
        if (grant !== 4'b0001 || gid !== 2'd0) begin
            $display("FAIL tmo_back_m0: grant=%b id=%0d want 0001/0", grant, gid); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_deferred;
        apply_reset;
        sel_m = 4'b0001;
        mreq  = 4'b0001;
        tick;
        mreq = 4'b0011;
        for (int unsigned e = 1; e <= 10; e++) tick;
        if (grant !== 4'b0001 || tmo !== 1'b0) begin
            $display("FAIL defer_hold: grant=%b tmo=%b want 0001/0", grant, tmo); n_fail++;
        end
        n_checks++;
        sel_m = 4'b0000;
        tick;
        if (grant !== 4'b0000 || tmo !== 1'b1) begin
            $display("FAIL defer_revoke: grant=%b tmo=%b want 0000/1", grant, tmo); n_fail++;
        end
        n_checks++;
        tick;
        if (grant !== 4'b0010 || tmo !== 1'b0) begin
            $display("FAIL defer_next: grant=%b tmo=%b want 0010/0", grant, tmo); n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_drop_at_timeout;
        apply_reset;
        mreq = 4'b0001;
        tick;
        mreq = 4'b0011;
        for (int unsigned e = 1; e <= 4; e++) tick;
        mreq = 4'b0010;
        tick;
        if (grant !== 4'b0000 || tmo !== 1'b0) begin
            $display("FAIL drop_tmo: grant=%b tmo=%b want 0000/0", grant, tmo); n_fail++;
        end
        n_checks++;
        tick;
        if (grant !== 4'b0010) begin $display("FAIL drop_tmo_next: got %b want 0010", grant); n_fail++; end
        n_checks++;
    endtask

    task automatic test_max_hold_zero;
        apply_reset;
        mreq = 4'b0001;
        tick;
        mreq = 4'b0011;
        for (int unsigned c = 0; c < 1000; c++) begin
            tick;
            if (grant0 !== 4'b0001 || tmo0 !== 1'b0) begin
                $display("FAIL nohold_c%0d: grant=%b tmo=%b want 0001/0", c, grant0, tmo0); n_fail++;
            end
            n_checks++;
        end
    endtask

    initial begin
        rst_n  = 1'b1;
        mreq   = '0;
        rnw_m  = '0;
        sel_m  = '0;
        dbus_m = '0;
        abus_m = '0;
        dbus_s = '0;
        test_reset;
        test_reset_mid_grant;
        test_round_robin;
        test_masking;
        test_no_record;
        test_timeout;
        test_deferred;
        test_drop_at_timeout;
        test_max_hold_zero;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
